pipe_borrow_select_decrementer: RTL

PIPE_BORROW_SELECT_DECREMENTER -- requirements
Module: pipe_borrow_select_decrementer

---
 rtl/bsd_pkg.sv | 12 +
 rtl/bsd_slice.sv | 15 +
 rtl/pipe_borrow_select_decrementer.sv | 101 ++++++++++
 3 files changed

// File: rtl/bsd_pkg.sv
// Shared defaults and slice-count helper for the borrow-select decrementer.
package bsd_pkg;

  localparam int DEF_ADDER_WIDTH = 15;
  localparam int DEF_BLOCK_WIDTH = 4;

  // Last slice absorbs the remainder, so round up.
  function automatic int num_slices(input int adder_width, input int block_width);
    return (adder_width + block_width - 1) / block_width;
  endfunction

endpackage

// File: rtl/bsd_slice.sv
// One borrow-select slice: both candidate differences plus an all-zero flag.
module bsd_slice #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] diff0,
  output logic [WIDTH-1:0] diff1,
  output logic             all_zero
);

  assign diff0    = a;
  assign diff1    = a - WIDTH'(1);
  assign all_zero = (a == '0);

endmodule

// File: rtl/pipe_borrow_select_decrementer.sv
// Two-stage valid/ready decrementer: stage 1 precomputes per-slice candidates,
// stage 2 ripples the slice borrow and selects the final difference.
module pipe_borrow_select_decrementer
  import bsd_pkg::*;
#(
  parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDER_WIDTH-1:0] operand_a_bsd,
  input  logic                   borrow_in_bsd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDER_WIDTH-1:0] diff_bsd,
  output logic                   borrow_out_bsd
);

  localparam int NUM_SLICES = num_slices(ADDER_WIDTH, BLOCK_WIDTH);

  logic [ADDER_WIDTH-1:0] d0, d1;
  logic [NUM_SLICES-1:0]  zero;

  logic                   s1_valid;
  logic [ADDER_WIDTH-1:0] s1_d0, s1_d1;
  logic [NUM_SLICES-1:0]  s1_zero;
  logic                   s1_borrow;

  logic                   s2_valid;
  logic                   s2_advance;
  logic [NUM_SLICES:0]    chain;
  logic [ADDER_WIDTH-1:0] sel;
  logic [ADDER_WIDTH-1:0] diff_next;

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
    localparam int LO = k * BLOCK_WIDTH;
    localparam int SW = ((ADDER_WIDTH - LO) < BLOCK_WIDTH) ? (ADDER_WIDTH - LO) : BLOCK_WIDTH;
    bsd_slice #(.WIDTH(SW)) u_slice (
      .a        (operand_a_bsd[LO +: SW]),
      .diff0    (d0[LO +: SW]),
      .diff1    (d1[LO +: SW]),
      .all_zero (zero[k])
    );
  end

  assign s2_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign out_valid  = s2_valid;

  // A borrow keeps propagating only through slices that are entirely zero.
  always_comb begin
    chain    = '0;
    sel      = '0;
    chain[0] = s1_borrow;
    for (int k = 0; k < NUM_SLICES; k++) begin
      chain[k+1] = chain[k] & s1_zero[k];
    end
    for (int i = 0; i < ADDER_WIDTH; i++) begin
      sel[i] = chain[i / BLOCK_WIDTH];
    end
    diff_next = (s1_d1 & sel) | (s1_d0 & ~sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_d0     <= '0;
      s1_d1     <= '0;
      s1_zero   <= '0;
      s1_borrow <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_d0     <= d0;
        s1_d1     <= d1;
        s1_zero   <= zero;
        s1_borrow <= borrow_in_bsd;
      end
    end
  end

  // Result registers only move when downstream can take them, so a stall holds them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid       <= 1'b0;
      diff_bsd       <= '0;
      borrow_out_bsd <= 1'b0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        diff_bsd       <= diff_next;
        borrow_out_bsd <= chain[NUM_SLICES];
      end
    end
  end

endmodule
